led_blinker_array: RTL and testbench
====================================

# led_blinker_array

Multi-channel successor to the single-output blinky: drives `CHANNELS` independent LED outputs, each programmable at run time to OFF, ON, BLINK (50% square wave of programmable half-period) or PWM (programmable duty at programmable step rate). Configuration arrives over a valid/ready write port, one channel per transfer. A global `sync` input re-aligns all channel phases. It sits between the board clock and the LED pins; a control block (UART or fixed ROM sequencer) drives the config port.

## Interface
- `CHANNELS`, 4: number of LED outputs (1..16).
- `CNT_WIDTH`, 24: width of per-channel prescale counter and `cfg_period`.
- `DUTY_WIDTH`, 8: width of PWM phase counter and `cfg_duty`.
- `clock`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  config transfer request.
- `cfg_ready`  out  1  block can accept config.
- `cfg_chan`  in  max(1,$clog2(CHANNELS))  target channel.
- `cfg_mode`  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM.
- `cfg_period`  in  CNT_WIDTH  prescale terminal count P.
- `cfg_duty`  in  DUTY_WIDTH  PWM duty D (ignored in other modes).
- `cfg_err`  out  1  one-cycle pulse: accepted transfer had `cfg_chan >= CHANNELS`.
- `sync`  in  1  restart all channel phases.
- `light_on`  out  CHANNELS  LED drive, bit i = channel i; registered.

## Operation
- Per channel state: mode(2), period(CNT_WIDTH), duty(DUTY_WIDTH), cnt(CNT_WIDTH), phase(DUTY_WIDTH), `light_on[i]`.
- Reset (while `reset`=1): all modes OFF, period=0, duty=0, cnt=0, phase=0, `light_on`=0, `cfg_ready`=0, `cfg_err`=0.
- `cfg_ready`=1 every cycle `reset` is low; transfer accepted at edge where `cfg_valid && cfg_ready`.
- Accept, valid channel c: load mode/period/duty; cnt←0, phase←0; `light_on[c]`← OFF:0, ON:1, BLINK:0, PWM:(D!=0). Other channels untouched.
- Accept, `cfg_chan >= CHANNELS`: no state change; `cfg_err`=1 for the following cycle only.
- Wrap event: at an edge where cnt==period, cnt←0; otherwise cnt←cnt+1. Counters run in all modes; only BLINK/PWM use them.
- BLINK: on wrap, `light_on` toggles. Low for P+1 cycles after accept, then high P+1, repeating. P=0 toggles every cycle.
- PWM: on wrap, phase←phase+1 (mod 2^DUTY_WIDTH); `light_on`←(new phase < D), updated with phase. Frame = 2^DUTY_WIDTH·(P+1) cycles, high for D·(P+1). D=0: always low; D=max: low for one step per frame.
- OFF/ON: `light_on` held at 0/1.
- `sync`=1: every channel cnt←0, phase←0; BLINK outputs ←0; PWM outputs ←(D!=0); OFF/ON unchanged.
- Same-edge `sync` and accept: accepted channel takes new config with cleared counters; all others synced. No transfer lost.
- Changing config of a running channel always restarts that channel's phase (no glitch-free handover required).

## Timing
- Config-to-output latency: `light_on[c]` shows new mode's initial value in the cycle immediately after the accept edge.
- `cfg_err` asserted in the cycle after the accepting edge, deasserted the next.
- `cfg_ready` goes high in the first cycle after `reset` falls; throughput one transfer per cycle.
- `reset` asserted mid-operation: all outputs return to reset values at that edge regardless of `cfg_valid`/`sync`.
- No combinational path from inputs to `light_on` or `cfg_err`.

## Test plan
- Reset: hold `reset` 3 cycles with `cfg_valid`=1 -> `light_on`=0, `cfg_ready`=0, no config applied; `cfg_ready`=1 cycle after release.
- BLINK ch1, P=3 -> `light_on[1]` 0 for 4 cycles, 1 for 4, period 8; other bits stay 0.
- PWM ch2, P=0, D=4, DUTY_WIDTH=4 -> high 4 of every 16 cycles; D=0 never high; D=15 low exactly 1 of 16.
- Back-to-back writes ch0 ON, ch3 BLINK P=0 on consecutive cycles -> both accepted; `light_on[0]`=1, `light_on[3]` toggles every cycle.
- `cfg_chan`=5 with CHANNELS=4 -> `cfg_err` one-cycle pulse, `light_on` unchanged.
- Two BLINK channels P=2 started 1 cycle apart, then `sync` -> both outputs 0 and identical thereafter; `sync` coincident with write -> written channel uses new config, aligned with others.

Source files
------------

// File: rtl/led_blinker_array.sv
// led_blinker_array: CHANNELS independent LED drivers, each OFF / ON / BLINK / PWM,
// programmed one channel per valid/ready transfer; a global sync re-aligns all phases.
module led_blinker_array #(
  parameter int CHANNELS   = 4,
  parameter int CNT_WIDTH  = 24,
  parameter int DUTY_WIDTH = 8,
  localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [1:0]            cfg_mode,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [DUTY_WIDTH-1:0] cfg_duty,
  output logic                  cfg_err,
  input  logic                  sync,
  output logic [CHANNELS-1:0]   light_on
);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PWM   = 2'd3;

  logic [1:0]            mode_q   [CHANNELS];
  logic [1:0]            mode_d   [CHANNELS];
  logic [CNT_WIDTH-1:0]  period_q [CHANNELS];
  logic [CNT_WIDTH-1:0]  period_d [CHANNELS];
  logic [DUTY_WIDTH-1:0] duty_q   [CHANNELS];
  logic [DUTY_WIDTH-1:0] duty_d   [CHANNELS];
  logic [CNT_WIDTH-1:0]  cnt_q    [CHANNELS];
  logic [CNT_WIDTH-1:0]  cnt_d    [CHANNELS];
  logic [DUTY_WIDTH-1:0] phase_q  [CHANNELS];
  logic [DUTY_WIDTH-1:0] phase_d  [CHANNELS];
  logic [CHANNELS-1:0]   light_q;
  logic [CHANNELS-1:0]   light_d;
  logic                  cfg_ready_q;
  logic                  cfg_ready_d;
  logic                  cfg_err_q;
  logic                  cfg_err_d;
  logic                  accept;
  logic                  chan_ok;

  // Next-state: free-running prescalers, mode-dependent output, then sync, then config load.
  always_comb begin
    accept      = cfg_valid && cfg_ready_q;
    chan_ok     = (int'(cfg_chan) < CHANNELS);
    cfg_ready_d = 1'b1;
    cfg_err_d   = accept && !chan_ok;
    light_d     = light_q;
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      cnt_d[i]    = cnt_q[i];
      phase_d[i]  = phase_q[i];

      if (sync) begin
        // Restart every phase; BLINK starts low, PWM starts at the top of its frame.
        cnt_d[i]   = '0;
        phase_d[i] = '0;
        if (mode_q[i] == MODE_BLINK)
          light_d[i] = 1'b0;
        else if (mode_q[i] == MODE_PWM)
          light_d[i] = (duty_q[i] != '0);
      end else if (cnt_q[i] == period_q[i]) begin
        cnt_d[i] = '0;
        case (mode_q[i])
          MODE_BLINK: light_d[i] = ~light_q[i];
          MODE_PWM: begin
            phase_d[i] = phase_q[i] + 1'b1;
            light_d[i] = (phase_d[i] < duty_q[i]);
          end
          default: ;
        endcase
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      // OFF/ON levels are held regardless of counter activity.
      if (mode_q[i] == MODE_OFF) light_d[i] = 1'b0;
      if (mode_q[i] == MODE_ON)  light_d[i] = 1'b1;

      // A write overrides sync and counting for its own channel only.
      if (accept && chan_ok && (cfg_chan == CHAN_W'(i))) begin
        mode_d[i]   = cfg_mode;
        period_d[i] = cfg_period;
        duty_d[i]   = cfg_duty;
        cnt_d[i]    = '0;
        phase_d[i]  = '0;
        case (cfg_mode)
          MODE_ON:  light_d[i] = 1'b1;
          MODE_PWM: light_d[i] = (cfg_duty != '0);
          default:  light_d[i] = 1'b0;
        endcase
      end
    end
  end

  // State registers with synchronous reset to all-off.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        cnt_q[i]    <= '0;
        phase_q[i]  <= '0;
      end
      light_q     <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        cnt_q[i]    <= cnt_d[i];
        phase_q[i]  <= phase_d[i];
      end
      light_q     <= light_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign light_on  = light_q;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_led_blinker_array.sv
// Scoreboard bench for led_blinker_array: expected outputs are derived from each
// channel's mode and start time with closed-form formulas, queued per edge, checked at negedge.
module tb_led_blinker_array;
  localparam int CH  = 5;
  localparam int CW  = 8;
  localparam int DW  = 4;
  localparam int CHW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CHW-1:0] cfg_chan = '0;
  logic [1:0]    cfg_mode = '0;
  logic [CW-1:0] cfg_period = '0;
  logic [DW-1:0] cfg_duty = '0;
  logic          cfg_err;
  logic          sync = 1'b0;
  logic [CH-1:0] light_on;

  led_blinker_array #(.CHANNELS(CH), .CNT_WIDTH(CW), .DUTY_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .cfg_err(cfg_err), .sync(sync), .light_on(light_on)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [CH-1:0] light;
    logic          err;
    logic          ready;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  string phase_tag = "reset";

  // Reference state: mode, period, duty and the edge index at which the phase started.
  int    m_mode[CH];
  int    m_p[CH];
  int    m_d[CH];
  int    m_t0[CH];
  int    n = 0;
  logic  m_ready = 1'b0;
  logic  m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%0h expected=%0h", phase_tag, tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int c);
    int k, step;
    k    = n - m_t0[c];
    step = k / (m_p[c] + 1);
    case (m_mode[c])
      1:       return 1'b1;
      2:       return logic'(step % 2);
      3:       return ((step % (1 << DW)) < m_d[c]);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    exp_t e;
    logic acc;
    n++;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = 0; m_p[c] = 0; m_d[c] = 0; m_t0[c] = n;
      end
      m_ready = 1'b0;
      m_err   = 1'b0;
    end else begin
      acc   = cfg_valid && m_ready;
      m_err = 1'b0;
      if (sync)
        for (int c = 0; c < CH; c++) m_t0[c] = n;
      if (acc) begin
        if (int'(cfg_chan) < CH) begin
          m_mode[cfg_chan] = int'(cfg_mode);
          m_p[cfg_chan]    = int'(cfg_period);
          m_d[cfg_chan]    = int'(cfg_duty);
          m_t0[cfg_chan]   = n;
        end else begin
          m_err = 1'b1;
        end
      end
      m_ready = 1'b1;
    end
    for (int c = 0; c < CH; c++) e.light[c] = exp_bit(c);
    e.err   = m_err;
    e.ready = m_ready;
    sb.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) cycle();
  endtask

  task automatic write(input int ch, input int mode, input int p, input int d, input logic s);
    cfg_valid  = 1'b1;
    cfg_chan   = CHW'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = CW'(p);
    cfg_duty   = DW'(d);
    sync       = s;
    cycle();
    cfg_valid  = 1'b0;
    sync       = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("light_on",  32'(light_on),  32'(e.light));
      chk("cfg_err",   32'(cfg_err),   32'(e.err));
      chk("cfg_ready", 32'(cfg_ready), 32'(e.ready));
    end
  end

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 0; m_p[c] = 0; m_d[c] = 0; m_t0[c] = 0;
    end
    // Reset held with a pending write that must not land.
    cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_mode = 2'd1;
    idle(3);
    phase_tag = "release";
    reset = 1'b0; cfg_valid = 1'b0;
    idle(2);

    phase_tag = "blink_p3";
    write(1, 2, 3, 0, 1'b0);
    idle(20);

    phase_tag = "pwm_d4";
    write(2, 3, 0, 4, 1'b0);
    idle(34);
    phase_tag = "pwm_d0";
    write(2, 3, 0, 0, 1'b0);
    idle(20);
    phase_tag = "pwm_d15";
    write(2, 3, 0, 15, 1'b0);
    idle(34);
    phase_tag = "pwm_p2";
    write(2, 3, 2, 5, 1'b0);
    idle(60);

    phase_tag = "back_to_back";
    write(0, 1, 0, 0, 1'b0);
    write(3, 2, 0, 0, 1'b0);
    idle(10);

    phase_tag = "bad_chan";
    write(5, 1, 0, 0, 1'b0);
    idle(2);
    write(7, 2, 0, 0, 1'b0);
    write(6, 1, 0, 0, 1'b0);
    idle(3);

    phase_tag = "sync";
    write(1, 2, 2, 0, 1'b0);
    write(4, 2, 2, 0, 1'b0);
    idle(5);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    idle(9);

    phase_tag = "sync_write";
    idle(1);
    write(0, 2, 2, 0, 1'b1);
    idle(10);

    phase_tag = "mid_reset";
    reset = 1'b1; cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_mode = 2'd1; sync = 1'b1;
    cycle();
    reset = 1'b0; cfg_valid = 1'b0; sync = 1'b0;
    idle(3);

    @(negedge clock);
    #1;
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
